// File: rtl/usb_fifo_rdport.sv
// Register-bus read port serving a 32-bit FWFT capture FIFO byte-by-byte.
// Define USB_FIFO_RDPORT_WORDCNT_EN to expose a consumed-word counter at STAT bytes 1-2.

module usb_fifo_rdport #(
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [5:0] pDATA_ADDR    = 6'd20,
    parameter logic [5:0] pSTAT_ADDR    = 6'd21,
    parameter logic [5:0] pCTRL_ADDR    = 6'd22
) (
    input  logic                     cwusb_clk,
    input  logic                     reset_i,
    input  logic [5:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datao,
    output logic [7:0]               reg_datai,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic                     reg_addrvalid,
    input  logic [31:0]              fifo_dout,
    input  logic                     fifo_empty,
    output logic                     fifo_rd,
    output logic                     underflow_o,
    output logic                     flushing_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] buf_q;
    logic        buf_valid_q;
    logic        fifo_rd_q;
    logic        flushing_q;
    logic        flushing_d;

    logic        rd_q;
    logic        active_q;
    logic        active_d;
    logic        underflow_q;
    logic        underflow_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [7:0]  rdata_q;
    logic [7:0]  rdata_d;
    logic [7:0]  stat_byte;

`ifdef USB_FIFO_RDPORT_WORDCNT_EN
    logic [15:0] wcnt_q;
    logic [15:0] wcnt_d;
`endif

    logic rd_rise;
    logic rd_fall;
    logic sel_data;
    logic sel_stat;
    logic sel_ctrl;
    logic byte0;
    logic ctrl_wr;
    logic flush_req;
    logic unf_clr;
    logic unf_set;
    logic start_data;
    logic consume;

    logic unused_datao;
    assign unused_datao = ^reg_datao[7:2];

    assign rd_rise    = reg_read & ~rd_q;
    assign rd_fall    = ~reg_read & rd_q;
    assign sel_data   = reg_addrvalid & (reg_address == pDATA_ADDR);
    assign sel_stat   = reg_addrvalid & (reg_address == pSTAT_ADDR);
    assign sel_ctrl   = reg_addrvalid & (reg_address == pCTRL_ADDR);
    assign byte0      = (reg_bytecnt[1:0] == 2'd0);
    assign ctrl_wr    = reg_write & sel_ctrl & (reg_bytecnt == '0);
    assign flush_req  = ctrl_wr & reg_datao[0];
    assign unf_clr    = ctrl_wr & reg_datao[1];
    assign start_data = rd_rise & sel_data;
    assign unf_set    = start_data & byte0 & ~buf_valid_q;
    assign consume    = rd_fall & sel_data & (idx_q == 2'd3)
                      & active_q & (state_q == VALID);

    assign flushing_d = flush_req | ((state_q == FLUSH) & ~fifo_empty);

    // Prefetch pop is registered; flush pops track fifo_empty live so
    // the strobe can never land on an empty FIFO.
    assign fifo_rd     = fifo_rd_q | ((state_q == FLUSH) & ~fifo_empty);
    assign flushing_o  = flushing_q;
    assign underflow_o = underflow_q;
    assign reg_datai   = rdata_q;

    always_comb begin
        idx_d = idx_q;
        if (start_data) begin
            idx_d = reg_bytecnt[1:0];
        end

        active_d = active_q;
        if (flush_req || consume) begin
            active_d = 1'b0;
        end else if (start_data && byte0) begin
            active_d = buf_valid_q;
        end

        underflow_d = underflow_q;
        if (unf_set) begin
            underflow_d = 1'b1;
        end else if (unf_clr) begin
            underflow_d = 1'b0;
        end

`ifdef USB_FIFO_RDPORT_WORDCNT_EN
        wcnt_d = wcnt_q;
        if (flush_req) begin
            wcnt_d = 16'h0000;
        end else if (consume) begin
            wcnt_d = wcnt_q + 16'h0001;
        end
`endif

        stat_byte = 8'h00;
        if (reg_bytecnt == '0) begin
            stat_byte = {4'b0000, flushing_q, underflow_q,
                         fifo_empty, buf_valid_q};
        end
`ifdef USB_FIFO_RDPORT_WORDCNT_EN
        else if (reg_bytecnt == pBYTECNT_SIZE'(1)) begin
            stat_byte = wcnt_q[7:0];
        end else if (reg_bytecnt == pBYTECNT_SIZE'(2)) begin
            stat_byte = wcnt_q[15:8];
        end
`endif

        // Next-state index/active so data is valid one cycle after the rise.
        rdata_d = 8'h00;
        unique case (1'b1)
            sel_data: begin
                if (active_d) begin
                    rdata_d = buf_q[{idx_d, 3'b000} +: 8];
                end
            end
            sel_stat: rdata_d = stat_byte;
            default:  rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            buf_q       <= 32'h0;
            buf_valid_q <= 1'b0;
            fifo_rd_q   <= 1'b0;
            flushing_q  <= 1'b0;
        end else begin
            fifo_rd_q  <= 1'b0;
            flushing_q <= flushing_d;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_q   <= 1'b1;
                        buf_q       <= fifo_dout;
                        buf_valid_q <= 1'b1;
                        state_q     <= VALID;
                    end
                end
                VALID: begin
                    if (consume) begin
                        buf_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (flush_req) begin
                fifo_rd_q   <= 1'b0;
                buf_valid_q <= 1'b0;
                state_q     <= FLUSH;
            end
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            rd_q        <= 1'b0;
            idx_q       <= 2'd0;
            active_q    <= 1'b0;
            underflow_q <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            rd_q        <= reg_read;
            idx_q       <= idx_d;
            active_q    <= active_d;
            underflow_q <= underflow_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef USB_FIFO_RDPORT_WORDCNT_EN
    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            wcnt_q <= 16'h0000;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_usb_fifo_rdport.sv
// Randomized bench for usb_fifo_rdport against a word-queue reference model.
// Honours USB_FIFO_RDPORT_WORDCNT_EN for the STAT counter bytes.

module tb_usb_fifo_rdport;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        underflow;
    logic        flushing;

    always #5 clk = ~clk;

    usb_fifo_rdport dut (
        .cwusb_clk     (clk),
        .reset_i       (rst),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd       (fifo_rd),
        .underflow_o   (underflow),
        .flushing_o    (flushing)
    );

    // External FWFT FIFO
    logic [31:0] fmem [0:4095];
    int          fhead = 0;
    int          ftail = 0;
    int          pops  = 0;

    assign fifo_empty = (fhead == ftail);
    assign fifo_dout  = fmem[fhead[11:0]];

    // Reference model: every word not yet consumed, head first
    logic [31:0] mq[$];
    bit          act;
    bit          m_unf;
    logic [15:0] wcnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (fifo_rd) begin
            chk("rd_nonempty", fifo_empty, 1'b0);
            if (!fifo_empty) begin
                fhead <= fhead + 1;
                pops  <= pops + 1;
            end
        end
    end

    task automatic push(input logic [31:0] w);
        fmem[ftail[11:0]] = w;
        ftail++;
        mq.push_back(w);
    endtask

    task automatic lvl_chk();
        int exp_lvl;
        exp_lvl = (mq.size() > 0) ? mq.size() - 1 : 0;
        chk("fifo_lvl", ftail - fhead, exp_lvl);
        chk("unf_pin", underflow, m_unf);
        chk("flush_pin", flushing, 1'b0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        lvl_chk();
    endtask

    task automatic rd_byte(input logic [6:0] bc, output logic [7:0] got);
        logic [1:0]  i;
        logic [31:0] w;
        logic [7:0]  exp;
        @(negedge clk);
        reg_address   = 6'd20;
        reg_addrvalid = 1'b1;
        reg_bytecnt   = bc;
        reg_read      = 1'b1;
        i = bc[1:0];
        if (i == 2'd0) begin
            act = (mq.size() > 0);
            if (!act) m_unf = 1'b1;
        end
        w = 32'h0;
        if (act) w = mq[0];
        exp = w[{i, 3'b000} +: 8];
        @(negedge clk);
        got = reg_datai;
        chk("data", got, exp);
        reg_read = 1'b0;
        @(negedge clk);
        if (i == 2'd3 && act) begin
            void'(mq.pop_front());
            wcnt++;
            act = 1'b0;
        end
        reg_addrvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_stat(input logic [6:0] bc, output logic [7:0] got);
        logic [7:0] exp;
        exp = 8'h00;
        if (bc == 7'd0) begin
            exp = {5'b00000, m_unf, (mq.size() < 2), (mq.size() > 0)};
        end
`ifdef USB_FIFO_RDPORT_WORDCNT_EN
        if (bc == 7'd1) exp = wcnt[7:0];
        if (bc == 7'd2) exp = wcnt[15:8];
`endif
        @(negedge clk);
        reg_address   = 6'd21;
        reg_addrvalid = 1'b1;
        reg_bytecnt   = bc;
        reg_read      = 1'b1;
        @(negedge clk);
        got = reg_datai;
        chk("stat", got, exp);
        reg_read = 1'b0;
        @(negedge clk);
        reg_addrvalid = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [6:0] bc, input logic [7:0] v);
        int lvl0;
        int p0;
        int t;
        lvl0 = ftail - fhead;
        p0   = pops;
        @(negedge clk);
        reg_address   = 6'd22;
        reg_addrvalid = 1'b1;
        reg_bytecnt   = bc;
        reg_datao     = v;
        reg_write     = 1'b1;
        @(negedge clk);
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
        if (bc == 7'd0) begin
            if (v[1]) m_unf = 1'b0;
            if (v[0]) begin
                chk("flush_hi", flushing, 1'b1);
                t = 0;
                while (flushing && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("flush_done", flushing, 1'b0);
                chk("flush_pops", pops - p0, lvl0);
                mq.delete();
                act  = 1'b0;
                wcnt = 16'h0;
            end
        end
        settle();
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w0;
        logic [6:0]  bc;
        int          p0;
        int          len;
        int          op;

        for (int k = 0; k < 4096; k++) fmem[k] = 32'h0;
        act  = 1'b0;
        m_unf = 1'b0;
        wcnt = 16'h0;
        rst = 1'b1;
        reg_address = 6'd0;
        reg_bytecnt = 7'd0;
        reg_datao = 8'h00;
        reg_read = 1'b0;
        reg_write = 1'b0;
        reg_addrvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_datai", reg_datai, 8'h00);
        chk("rst_rd", fifo_rd, 1'b0);
        chk("rst_unf", underflow, 1'b0);
        chk("rst_flush", flushing, 1'b0);
        rst = 1'b0;
        settle();

        // Basic word, then refill after byte 3
        @(negedge clk);
        p0 = pops;
        push(32'hDDCCBBAA);
        push(32'h55667788);
        settle();
        chk("prefetch_pops", pops - p0, 1);
        rd_byte(7'd0, b); chk("b0", b, 8'hAA);
        rd_byte(7'd1, b); chk("b1", b, 8'hBB);
        rd_byte(7'd2, b); chk("b2", b, 8'hCC);
        rd_byte(7'd3, b); chk("b3", b, 8'hDD);
        lvl_chk();
        chk("refill_pops", pops - p0, 2);
        for (int k = 0; k < 4; k++) rd_byte(7'(k), b);
        lvl_chk();

        // Underflow on empty FIFO
        for (int k = 0; k < 4; k++) begin
            rd_byte(7'(k), b);
            chk("unf_byte", b, 8'h00);
        end
        rd_stat(7'd0, b); chk("stat_unf", b, 8'h06);
        wr_ctrl(7'd1, 8'h03);
        rd_stat(7'd0, b); chk("stat_ign", b, 8'h06);
        wr_ctrl(7'd0, 8'h02);
        rd_stat(7'd0, b); chk("stat_clr", b, 8'h02);

        // Flush with a partially read word
        @(negedge clk);
        push(32'h01020304);
        push(32'h05060708);
        push(32'h090A0B0C);
        settle();
        rd_byte(7'd0, b);
        rd_byte(7'd1, b);
        p0 = pops;
        wr_ctrl(7'd0, 8'h01);
        chk("flush2", pops - p0, 2);
        rd_stat(7'd0, b); chk("stat_flush", b, 8'h02);

        // Partial word re-read
        @(negedge clk);
        push(32'h11223344);
        settle();
        rd_byte(7'd0, b); chk("p0", b, 8'h44);
        rd_byte(7'd1, b); chk("p1", b, 8'h33);
        rd_byte(7'd0, b); chk("p2", b, 8'h44);
        rd_byte(7'd1, b); chk("p3", b, 8'h33);
        rd_byte(7'd2, b); chk("p4", b, 8'h22);
        rd_byte(7'd3, b); chk("p5", b, 8'h11);
        lvl_chk();

        // Reset in the middle of a flush
        rd_byte(7'd0, b);
        @(negedge clk);
        for (int k = 0; k < 10; k++) push(32'hA0000000 + 32'(k));
        settle();
        @(negedge clk);
        reg_address   = 6'd22;
        reg_addrvalid = 1'b1;
        reg_bytecnt   = 7'd0;
        reg_datao     = 8'h01;
        reg_write     = 1'b1;
        @(negedge clk);
        reg_write   = 1'b0;
        reg_address = 6'd21;
        repeat (2) @(negedge clk);
        chk("pre_rst_flush", flushing, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_datai", reg_datai, 8'h00);
        chk("arst_rd", fifo_rd, 1'b0);
        chk("arst_unf", underflow, 1'b0);
        chk("arst_flush", flushing, 1'b0);
        reg_addrvalid = 1'b0;
        mq.delete();
        for (int k = fhead; k < ftail; k++) mq.push_back(fmem[k[11:0]]);
        act   = 1'b0;
        m_unf = 1'b0;
        wcnt  = 16'h0;
        w0    = mq[0];
        @(negedge clk);
        rst = 1'b0;
        p0  = pops;
        settle();
        chk("rst_prefetch", pops - p0, 1);
        rd_byte(7'd0, b); chk("rst_head", b, {24'h0, w0[7:0]});

        // Word counter across 258 consumed words
        wr_ctrl(7'd0, 8'h01);
        for (int k = 0; k < 258; k++) begin
            @(negedge clk);
            push($urandom);
            settle();
            for (int j = 0; j < 4; j++) rd_byte(7'(j), b);
        end
        rd_stat(7'd1, b);
`ifdef USB_FIFO_RDPORT_WORDCNT_EN
        chk("wcnt_lo", b, 8'h02);
`else
        chk("wcnt_lo", b, 8'h00);
`endif
        rd_stat(7'd2, b);
`ifdef USB_FIFO_RDPORT_WORDCNT_EN
        chk("wcnt_hi", b, 8'h01);
`else
        chk("wcnt_hi", b, 8'h00);
`endif
        wr_ctrl(7'd0, 8'h01);
        rd_stat(7'd1, b); chk("wcnt_lo0", b, 8'h00);
        rd_stat(7'd2, b); chk("wcnt_hi0", b, 8'h00);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 2 && ftail < 3500) begin
                @(negedge clk);
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) push($urandom);
                settle();
            end else if (op <= 6) begin
                bc = ($urandom_range(0, 9) < 7) ? 7'd0 : 7'($urandom_range(0, 127));
                len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) begin
                    rd_byte(bc, b);
                    bc = bc + 7'd1;
                end
                lvl_chk();
            end else if (op == 7) begin
                rd_stat(7'($urandom_range(0, 3)), b);
            end else if (op == 8) begin
                bc = ($urandom_range(0, 3) != 0) ? 7'd0 : 7'($urandom_range(1, 127));
                wr_ctrl(bc, 8'($urandom_range(0, 3)));
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                lvl_chk();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_fifo_rdport.md
Name: usb_fifo_rdport

Overview:
- Register-side consumer of the USB register bus: decodes data/status/control addresses, serves a 32-bit first-word-fall-through capture FIFO to the host byte-by-byte.
- Pre-fetches one FIFO word into a holding buffer so read data meets the "valid one cycle after reg_read" rule.
- Provides sticky underflow status and a host-commanded FIFO flush.

Parameters:
- pBYTECNT_SIZE, 7, width of reg_bytecnt.
- pDATA_ADDR, 6'd20, register address of FIFO data stream.
- pSTAT_ADDR, 6'd21, register address of status byte.
- pCTRL_ADDR, 6'd22, register address of control byte.

Ports:
- cwusb_clk  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- reg_address  in  6  register address from bus.
- reg_bytecnt  in  pBYTECNT_SIZE  byte index within transaction.
- reg_datao  in  8  write data.
- reg_datai  out  8  read data to bus.
- reg_read  in  1  read level, high while host reads.
- reg_write  in  1  one-cycle write strobe.
- reg_addrvalid  in  1  address valid.
- fifo_dout  in  32  FWFT FIFO head word.
- fifo_empty  in  1  FIFO empty.
- fifo_rd  out  1  one-cycle pop strobe.
- underflow_o  out  1  sticky underflow flag.
- flushing_o  out  1  high while in FLUSH state.

Behaviour:
- Reset values (async, immediate): reg_datai=0, fifo_rd=0, underflow_o=0, flushing_o=0, buffer=0, buf_valid=0, word_active=0, idx_q=0, state=IDLE.
- Events:
  - rd_rise = reg_read & ~reg_read_q.
  - rd_fall = ~reg_read & reg_read_q.
  - sel_X = reg_addrvalid & (reg_address==pX_ADDR).
- Pre-fetch FSM:
  - IDLE: if !fifo_empty, assert fifo_rd for 1 cycle, buffer<=fifo_dout, buf_valid<=1, go VALID.
  - VALID: hold buffer; on consume, buf_valid<=0, go IDLE. Refill happens in the next cycle at earliest.
  - FLUSH: flushing_o=1; fifo_rd=~fifo_empty every cycle; when fifo_empty, go IDLE.
- Data read:
  - On rd_rise & sel_DATA: idx_q<=reg_bytecnt[1:0].
  - If reg_bytecnt[1:0]==0, also word_active<=buf_valid; if buf_valid==0, underflow_o<=1.
- Consume: rd_fall & sel_DATA & idx_q==3 & word_active -> buffer consumed; word_active<=0.
- reg_datai is registered every cycle, so it is valid one cycle after rd_rise:
  - sel_DATA: word_active ? buffer[8*idx_q+:8] (little-endian, byte 0 = bits 7:0) : 8'h00.
  - sel_STAT: byte index 0 -> {4'b0, flushing_o, underflow_o, fifo_empty, buf_valid}; other indices -> 8'h00.
  - otherwise: 8'h00.
- Underflow word: all four bytes read as 0x00; no pop; buffer untouched.
- Control write, when reg_write & sel_CTRL & reg_bytecnt==0:
  - bit0=1: flush. buf_valid<=0, word_active<=0, go FLUSH from any state.
  - bit1=1: clear underflow_o.
  - Writes at other byte indices are ignored.
- Simultaneous events:
  - Flush and consume in the same cycle: flush wins.
  - Underflow set and clear in the same cycle: set wins.
- Non-multiple-of-4 reads: a partial word is not consumed and is re-read from byte 0 next transaction. Wrap of reg_bytecnt is harmless (only bits 1:0 used).
- fifo_rd is never asserted while fifo_empty=1.

Optional Feature:
- Macro USB_FIFO_RDPORT_WORDCNT_EN.
- Defined:
  - 16-bit wrapping counter of consumed words, cleared by reset and by flush.
  - Readable little-endian at pSTAT_ADDR byte indices 1 (low) and 2 (high).
- Undefined: counter absent; those indices read 8'h00.

Test Plan:
- Push 0xDDCCBBAA, 4 data reads (bytecnt 0..3): reg_datai = AA, BB, CC, DD, each valid 1 cycle after rd_rise; exactly one fifo_rd pulse for the pre-fetch; refill pops next word after byte 3 rd_fall.
- Empty FIFO, 4 data reads: all return 0x00; status read returns 0x06 (fifo_empty, underflow); write 0x02 to CTRL; status returns 0x02.
- Push 3 words, read 2 bytes, write 0x01 to CTRL: flushing_o high until FIFO empty, 2 fifo_rd pulses; status then 0x02; buffer invalid.
- Push 0x11223344, read bytes 0..1, end transaction, read 4 bytes: returns 44, 33, 44, 33, 22, 11; single word consumed.
- Assert reset_i mid-FLUSH with FIFO non-empty: all outputs 0 immediately; after release, FSM pre-fetches head word.
- With USB_FIFO_RDPORT_WORDCNT_EN, consume 258 words: STAT bytes 1,2 = 0x02, 0x01; after flush they read 0x00, 0x00.
